// File: rtl/tmr_pkg.sv
// rtl/tmr_pkg.sv - shared constants, types and helpers for the TMR counter
package tmr_pkg;

  localparam int REPLICAS = 3;
  // Widest replica the helper functions accept; callers size-cast in and out.
  localparam int MAX_W = 64;

  typedef logic [REPLICAS-1:0] mismatch_t;

  // Bitwise two-out-of-three majority over a MAX_W-wide word.
  function automatic logic [MAX_W-1:0] maj3(input logic [MAX_W-1:0] a,
                                            input logic [MAX_W-1:0] b,
                                            input logic [MAX_W-1:0] c);
    return (a & b) | (b & c) | (a & c);
  endfunction

  // Number of set bits in a mismatch vector (0..3).
  function automatic logic [1:0] popcnt3(input mismatch_t m);
    return {1'b0, m[0]} + {1'b0, m[1]} + {1'b0, m[2]};
  endfunction

endpackage

// File: rtl/tmr_count_cell.sv
// rtl/tmr_count_cell.sv - one counter replica with its own next-state logic
module tmr_count_cell
  import tmr_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter bit SCRUB_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] vote,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] src;
  logic [WIDTH-1:0] next_d;

  // Pick the advance source (voted or own value), then apply load > count > hold.
  always_comb begin
    src    = SCRUB_EN ? vote : q;
    next_d = src;
    if (load) begin
      next_d = load_val;
    end else if (enable) begin
      next_d = up_dn ? (src + WIDTH'(1)) : (src - WIDTH'(1));
    end
  end

  // Replica register; the name q is kept stable so faults can be forced onto it.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else begin
      q <= next_d;
    end
  end

endmodule

// File: rtl/tmr_counter_scrub.sv
// rtl/tmr_counter_scrub.sv - triple-redundant up/down counter with voter and scrub
module tmr_counter_scrub
  import tmr_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int ERR_CNT_W = 8,
  parameter bit SCRUB_EN  = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 up_dn,
  input  logic                 load,
  input  logic [WIDTH-1:0]     load_val,
  input  logic                 err_clr,
  output logic [WIDTH-1:0]     q_out,
  output logic [2:0]           err_flag,
  output logic                 err_any,
  output logic                 uncorrectable,
  output logic [ERR_CNT_W-1:0] err_count
);

  logic [WIDTH-1:0]     r0, r1, r2;
  logic [WIDTH-1:0]     vote;
  mismatch_t            m;
  mismatch_t            err_flag_q;
  logic                 err_any_q;
  logic                 uncorrectable_q;
  logic [ERR_CNT_W-1:0] err_count_q;
  logic [ERR_CNT_W-1:0] err_count_d;

  tmr_count_cell #(.WIDTH(WIDTH), .SCRUB_EN(SCRUB_EN)) u_rep0 (
    .clk(clk), .rst(rst), .enable(enable), .up_dn(up_dn), .load(load),
    .load_val(load_val), .vote(vote), .q(r0)
  );

  tmr_count_cell #(.WIDTH(WIDTH), .SCRUB_EN(SCRUB_EN)) u_rep1 (
    .clk(clk), .rst(rst), .enable(enable), .up_dn(up_dn), .load(load),
    .load_val(load_val), .vote(vote), .q(r1)
  );

  tmr_count_cell #(.WIDTH(WIDTH), .SCRUB_EN(SCRUB_EN)) u_rep2 (
    .clk(clk), .rst(rst), .enable(enable), .up_dn(up_dn), .load(load),
    .load_val(load_val), .vote(vote), .q(r2)
  );

  // Vote and per-replica disagreement are taken from the pre-update register contents.
  always_comb begin
    vote = WIDTH'(maj3(MAX_W'(r0), MAX_W'(r1), MAX_W'(r2)));
    m    = {(r2 != vote), (r1 != vote), (r0 != vote)};
  end

  // Mismatch-event counter: clear beats increment, increment saturates at all-ones.
  always_comb begin
    err_count_d = err_count_q;
    if (err_clr) begin
      err_count_d = '0;
    end else if ((|m) && (err_count_q != {ERR_CNT_W{1'b1}})) begin
      err_count_d = err_count_q + ERR_CNT_W'(1);
    end
  end

  // Registered fault observability; flags describe the previous cycle only.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_flag_q      <= '0;
      err_any_q       <= 1'b0;
      uncorrectable_q <= 1'b0;
      err_count_q     <= '0;
    end else begin
      err_flag_q      <= m;
      err_any_q       <= |m;
      uncorrectable_q <= (popcnt3(m) >= 2'd2);
      err_count_q     <= err_count_d;
    end
  end

  assign q_out         = vote;
  assign err_flag      = err_flag_q;
  assign err_any       = err_any_q;
  assign uncorrectable = uncorrectable_q;
  assign err_count     = err_count_q;

endmodule

// File: tb/tb_tmr_counter_scrub.sv
// tb/tb_tmr_counter_scrub.sv - directed self-checking bench for the TMR counter
module tb_tmr_counter_scrub;

  logic       clk = 1'b0;
  int         checks = 0;
  int         failures = 0;

  // Scrubbing build, 8-bit error counter
  logic       rst, enable, up_dn, load, err_clr;
  logic [7:0] load_val;
  logic [7:0] q_out;
  logic [2:0] err_flag;
  logic       err_any, uncorrectable;
  logic [7:0] err_count;

  // Non-scrubbing build, 2-bit error counter
  logic       rst_b, enable_b, up_dn_b, load_b, err_clr_b;
  logic [7:0] load_val_b;
  logic [7:0] q_out_b;
  logic [2:0] err_flag_b;
  logic       err_any_b, uncorrectable_b;
  logic [1:0] err_count_b;

  always #5 clk = ~clk;

  tmr_counter_scrub #(.WIDTH(8), .ERR_CNT_W(8), .SCRUB_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .enable(enable), .up_dn(up_dn), .load(load),
    .load_val(load_val), .err_clr(err_clr), .q_out(q_out), .err_flag(err_flag),
    .err_any(err_any), .uncorrectable(uncorrectable), .err_count(err_count)
  );

  tmr_counter_scrub #(.WIDTH(8), .ERR_CNT_W(2), .SCRUB_EN(1'b0)) dut_b (
    .clk(clk), .rst(rst_b), .enable(enable_b), .up_dn(up_dn_b), .load(load_b),
    .load_val(load_val_b), .err_clr(err_clr_b), .q_out(q_out_b), .err_flag(err_flag_b),
    .err_any(err_any_b), .uncorrectable(uncorrectable_b), .err_count(err_count_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_a(input string tag, input logic [7:0] q, input logic [2:0] f,
                       input logic any, input logic unc, input logic [7:0] cnt);
    chk({tag, ".q_out"}, 32'(q_out), 32'(q));
    chk({tag, ".err_flag"}, 32'(err_flag), 32'(f));
    chk({tag, ".err_any"}, 32'(err_any), 32'(any));
    chk({tag, ".uncorrectable"}, 32'(uncorrectable), 32'(unc));
    chk({tag, ".err_count"}, 32'(err_count), 32'(cnt));
  endtask

  task automatic chk_b(input string tag, input logic [7:0] q, input logic [2:0] f,
                       input logic [1:0] cnt);
    chk({tag, ".q_out_b"}, 32'(q_out_b), 32'(q));
    chk({tag, ".err_flag_b"}, 32'(err_flag_b), 32'(f));
    chk({tag, ".err_count_b"}, 32'(err_count_b), 32'(cnt));
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; up_dn = 1'b1; load = 1'b0; err_clr = 1'b0; load_val = 8'h00;
    rst_b = 1'b1; enable_b = 1'b0; up_dn_b = 1'b1; load_b = 1'b0; err_clr_b = 1'b0;
    load_val_b = 8'h00;

    // Reset state
    tick();
    chk_a("reset", 8'h00, 3'b000, 1'b0, 1'b0, 8'd0);
    rst = 1'b0;

    // Count up five
    enable = 1'b1; up_dn = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk_a("count5", 8'h05, 3'b000, 1'b0, 1'b0, 8'd0);

    // Single-replica upset on replica 1, scrubbed at the next edge
    force dut.u_rep1.q = 8'h0A;
    #1 release dut.u_rep1.q;
    chk("single.vote_pre", 32'(q_out), 32'h05);
    tick();
    chk_a("single.edge", 8'h06, 3'b010, 1'b1, 1'b0, 8'd1);
    chk("single.rep1_repaired", 32'(dut.u_rep1.q), 32'h06);
    tick();
    chk_a("single.after", 8'h07, 3'b000, 1'b0, 1'b0, 8'd1);

    // Two replicas upset: vote(07,FF,EF)=EF, replicas 0 and 1 disagree
    force dut.u_rep1.q = 8'hFF;
    force dut.u_rep2.q = 8'hEF;
    #1;
    release dut.u_rep1.q;
    release dut.u_rep2.q;
    chk("double.vote_pre", 32'(q_out), 32'hEF);
    tick();
    chk_a("double.edge", 8'hF0, 3'b011, 1'b1, 1'b1, 8'd2);
    tick();
    chk_a("double.after", 8'hF1, 3'b000, 1'b0, 1'b0, 8'd2);

    // Load then wrap upward
    load = 1'b1; load_val = 8'hFE;
    tick();
    chk("wrap.load_fe", 32'(q_out), 32'hFE);
    load = 1'b0;
    tick(); chk("wrap.up_ff", 32'(q_out), 32'hFF);
    tick(); chk("wrap.up_00", 32'(q_out), 32'h00);
    tick(); chk("wrap.up_01", 32'(q_out), 32'h01);

    // Load then wrap downward
    load = 1'b1; load_val = 8'h01;
    tick(); chk("wrap.load_01", 32'(q_out), 32'h01);
    load = 1'b0; up_dn = 1'b0;
    tick(); chk("wrap.dn_00", 32'(q_out), 32'h00);
    tick(); chk("wrap.dn_ff", 32'(q_out), 32'hFF);

    // Idle scrub: replica 2 repaired while the count holds
    enable = 1'b0;
    force dut.u_rep2.q = 8'h12;
    #1 release dut.u_rep2.q;
    tick();
    chk_a("idle.edge", 8'hFF, 3'b100, 1'b1, 1'b0, 8'd3);
    chk("idle.rep2_repaired", 32'(dut.u_rep2.q), 32'hFF);

    // Clear wins over a simultaneous mismatch
    force dut.u_rep0.q = 8'h33;
    #1 release dut.u_rep0.q;
    err_clr = 1'b1;
    tick();
    chk_a("clr.edge", 8'hFF, 3'b001, 1'b1, 1'b0, 8'd0);
    err_clr = 1'b0;

    // Count again, take a fault, then reset overrides load/enable mid-fault
    enable = 1'b1; up_dn = 1'b1;
    tick();
    chk_a("pre_rst.count", 8'h00, 3'b000, 1'b0, 1'b0, 8'd0);
    force dut.u_rep1.q = 8'h40;
    #1 release dut.u_rep1.q;
    tick();
    chk_a("pre_rst.fault", 8'h01, 3'b010, 1'b1, 1'b0, 8'd1);
    force dut.u_rep1.q = 8'h40;
    #1 release dut.u_rep1.q;
    rst = 1'b1; load = 1'b1; load_val = 8'h55; err_clr = 1'b0;
    tick();
    chk_a("mid_rst", 8'h00, 3'b000, 1'b0, 1'b0, 8'd0);
    rst = 1'b0; load = 1'b0; enable = 1'b0;

    // Non-scrubbing build: divergence persists until load
    rst_b = 1'b0; load_b = 1'b1; load_val_b = 8'h10;
    tick();
    chk_b("ns.load", 8'h10, 3'b000, 2'd0);
    load_b = 1'b0;
    force dut_b.u_rep2.q = 8'h77;
    #1 release dut_b.u_rep2.q;
    tick();
    chk_b("ns.fault1", 8'h10, 3'b100, 2'd1);
    chk("ns.rep2_diverged", 32'(dut_b.u_rep2.q), 32'h77);
    tick();
    chk_b("ns.fault2", 8'h10, 3'b100, 2'd2);
    load_b = 1'b1; load_val_b = 8'h20;
    tick();
    chk_b("ns.realign_edge", 8'h20, 3'b100, 2'd3);
    load_b = 1'b0;
    tick();
    chk_b("ns.realigned", 8'h20, 3'b000, 2'd3);

    // Saturation with a persistent fault on replica 0 while counting
    force dut_b.u_rep0.q = 8'h99;
    #1 release dut_b.u_rep0.q;
    enable_b = 1'b1; up_dn_b = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    chk_b("ns.saturate", 8'h26, 3'b001, 2'd3);
    chk("ns.uncorrectable", 32'(uncorrectable_b), 32'h0);
    chk("ns.err_any", 32'(err_any_b), 32'h1);
    err_clr_b = 1'b1;
    tick();
    chk_b("ns.clr", 8'h27, 3'b001, 2'd0);
    err_clr_b = 1'b0;
    rst_b = 1'b1;
    tick();
    chk_b("ns.rst", 8'h00, 3'b000, 2'd0);
    chk("ns.rst_any", 32'(err_any_b), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
